// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : shared funct3 codes and FSM state type for the load/store unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align : lane extract/extend for loads, lane merge for sub-word stores
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? word[31:16] : word[15:0];

    unique case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      default: load_data = word;
    endcase

    // Only SB/SH ever reach the merge path; other codes pass the word through.
    merged = word;
    if (funct3 == F3_B) begin
      merged[{addr, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : single-outstanding RV32 load/store initiator for a
//                   word-addressed memory with combinational read data
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WordSize        = 32,
  parameter int WordsNumberLog2 = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       ReqValid,
  output logic                       ReqReady,
  input  logic                       ReqWrite,
  input  logic [2:0]                 ReqFunct3,
  input  logic [31:0]                ReqAddress,
  input  logic [31:0]                ReqWData,
  output logic                       RespValid,
  input  logic                       RespReady,
  output logic [31:0]                RespData,
  output logic                       RespError,
  output logic                       MemStatus,
  output logic [WordsNumberLog2-1:0] MemAddress,
  output logic [WordSize-1:0]        MemI,
  input  logic [WordSize-1:0]        MemQ
);

  lsu_state_t state_q, state_d;

  logic                       write_q;
  logic [2:0]                 funct3_q;
  logic [WordsNumberLog2+1:0] addr_q;
  logic [WordSize-1:0]        data_q;
  logic [31:0]                resp_data_q;
  logic                       resp_error_q;

  logic        accept;
  logic        req_error;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept = ReqValid && (state_q == IDLE);

  always_comb begin
    req_error = 1'b0;
    case (ReqFunct3)
      F3_B:    req_error = 1'b0;
      F3_BU:   req_error = ReqWrite;
      F3_H:    req_error = ReqAddress[0];
      F3_HU:   req_error = ReqWrite | ReqAddress[0];
      F3_W:    req_error = |ReqAddress[1:0];
      default: req_error = 1'b1;
    endcase
    if (ReqAddress[31:WordsNumberLog2+2] != '0) begin
      req_error = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_error)                              state_d = RESP;
          else if (ReqWrite && (ReqFunct3 == F3_W))   state_d = WRITE;
          else                                        state_d = READ;
        end
      end
      READ:    state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (RespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // data_q holds store data from accept; for SB/SH it is replaced by the merged word in READ.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_data_q  <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            write_q      <= ReqWrite;
            funct3_q     <= ReqFunct3;
            addr_q       <= ReqAddress[WordsNumberLog2+1:0];
            data_q       <= ReqWData;
            resp_data_q  <= 32'd0;
            resp_error_q <= req_error;
          end
        end
        READ: begin
          if (write_q) data_q      <= merged;
          else         resp_data_q <= load_data;
        end
        WRITE: begin
          resp_data_q  <= 32'd0;
          resp_error_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  lsu_align u_align (
    .word      (MemQ),
    .addr      (addr_q[1:0]),
    .funct3    (funct3_q),
    .wdata     (data_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign ReqReady   = (state_q == IDLE);
  assign RespValid  = (state_q == RESP);
  assign RespData   = resp_data_q;
  assign RespError  = resp_error_q;
  // Gated by Reset so an aborted store never reaches the memory edge.
  assign MemStatus  = (state_q == WRITE) && !Reset;
  assign MemAddress = addr_q[WordsNumberLog2+1:2];
  assign MemI       = (state_q == WRITE) ? data_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : scoreboard bench pairing the unit with a 256-word memory
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_data;
  logic        mem_status;
  logic [7:0]  mem_address;
  logic [31:0] mem_i, mem_q;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          wr_count;
  logic [31:0] last_wr;
  int          cyc;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t exp_q[$];
  bit   resp_seen;

  load_store_unit #(.WordSize(32), .WordsNumberLog2(8)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .ReqValid   (req_valid),
    .ReqReady   (req_ready),
    .ReqWrite   (req_write),
    .ReqFunct3  (req_funct3),
    .ReqAddress (req_address),
    .ReqWData   (req_wdata),
    .RespValid  (resp_valid),
    .RespReady  (resp_ready),
    .RespData   (resp_data),
    .RespError  (resp_error),
    .MemStatus  (mem_status),
    .MemAddress (mem_address),
    .MemI       (mem_i),
    .MemQ       (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_q = mem[mem_address];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_status) begin
      mem[mem_address] <= mem_i;
      wr_count         <= wr_count + 1;
      last_wr          <= mem_i;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] a, logic [2:0] f3);
    logic [31:0] s;
    s = w >> (8 * a);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] w, logic [1:0] a, logic [2:0] f3,
                                              logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3 == 3'b000) ? 32'h0000_00FF : (f3 == 3'b001) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (w & ~(mask << (8 * a))) | ((wd & mask) << (8 * a));
  endfunction

  // Scoreboard monitor: pops one expectation on the first visible cycle of each response.
  always @(negedge clk) begin
    if (rst) begin
      resp_seen = 1'b0;
    end else begin
      if (resp_valid && !resp_seen) begin
        resp_seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: got data %h err %b with nothing expected",
                   resp_data, resp_error);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
          check("latency", cyc + 1 - e.t_acc, e.lat);
        end
      end
      if (resp_valid && resp_ready) resp_seen = 1'b0;
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx]     = val;
    ref_mem[idx] = val;
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err,
                       input int lat, input bit expect_resp, output int t_acc);
    bit ok;
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = wr;
    req_funct3  = f3;
    req_address = addr;
    req_wdata   = wd;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no ReqReady expected ReqReady=1 within 50 cycles");
      req_valid = 1'b0;
      t_acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    t_acc = cyc;
    if (expect_resp) begin
      exp_q.push_back('{exp_data, exp_err, lat, cyc});
      if (wr && !exp_err)
        ref_mem[addr[9:2]] = model_store(ref_mem[addr[9:2]], addr[1:0], f3, wd);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int          t, tr, w0, nstores, bad;
    logic [2:0]  f3;
    logic [31:0] a, wd, ex;
    logic        wr;
    logic [2:0]  ld_codes [5];
    logic [2:0]  st_codes [3];
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_codes = '{3'b000, 3'b001, 3'b010};

    cyc = 0; wr_count = 0; last_wr = 32'd0; resp_seen = 1'b0;
    for (int i = 0; i < 256; i++) preload(i, 32'h1357_9BDF ^ (i * 32'h0101_0101));
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_status", {31'd0, mem_status}, 32'd0);
    check("rst_mem_address", {24'd0, mem_address}, 32'd0);
    check("rst_mem_i", mem_i, 32'd0);

    // Loads from a preloaded word
    preload(4, 32'h8899_AABB);
    issue(0, 3'b000, 32'h11, 0, 32'hFFFF_FFAA, 0, 2, 1, t);
    issue(0, 3'b100, 32'h11, 0, 32'h0000_00AA, 0, 2, 1, t);
    issue(0, 3'b001, 32'h12, 0, 32'hFFFF_8899, 0, 2, 1, t);
    issue(0, 3'b010, 32'h10, 0, 32'h8899_AABB, 0, 2, 1, t);
    wait_drain();

    // Stores: read-modify-write and full word
    w0 = wr_count;
    issue(1, 3'b000, 32'h12, 32'h55, 32'd0, 0, 3, 1, t);
    wait_drain();
    check("sb_write_count", wr_count - w0, 1);
    check("sb_write_data", last_wr, 32'h8855_AABB);
    issue(1, 3'b001, 32'h10, 32'h1234, 32'd0, 0, 3, 1, t);
    wait_drain();
    check("sh_mem4", mem[4], 32'h8855_1234);
    issue(1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 0, 2, 1, t);
    wait_drain();
    check("sw_mem4", mem[4], 32'hDEAD_BEEF);

    // Errors: no memory write, one-cycle response
    w0 = wr_count;
    issue(0, 3'b010, 32'h13,  0, 32'd0, 1, 1, 1, t);
    issue(1, 3'b001, 32'h11,  32'hFFFF, 32'd0, 1, 1, 1, t);
    issue(0, 3'b010, 32'h400, 0, 32'd0, 1, 1, 1, t);
    issue(0, 3'b011, 32'h10,  0, 32'd0, 1, 1, 1, t);
    issue(1, 3'b100, 32'h10,  32'h77, 32'd0, 1, 1, 1, t);
    wait_drain();
    check("err_no_write", wr_count - w0, 0);

    // Backpressure in RESP with a pending request held
    #1 resp_ready = 1'b0;
    issue(0, 3'b010, 32'h10, 0, 32'hDEAD_BEEF, 0, 2, 1, t);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b100; req_address = 32'h10;
    for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_resp_data", resp_data, 32'hDEAD_BEEF);
      check("bp_resp_error", {31'd0, resp_error}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    tr = cyc;
    issue(0, 3'b100, 32'h10, 0, 32'h0000_00EF, 0, 2, 1, t);
    check("bp_accept_edge", t, tr + 2);
    wait_drain();

    // Reset asserted during the WRITE cycle of an SB
    preload(5, 32'h0BAD_F00D);
    w0 = wr_count;
    issue(1, 3'b000, 32'h15, 32'h77, 32'd0, 0, 3, 0, t);
    @(posedge clk);
    #1;
    check("abort_in_write", {31'd0, mem_status}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_status_gated", {31'd0, mem_status}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_resp_data", resp_data, 32'd0);
    check("abort_resp_error", {31'd0, resp_error}, 32'd0);
    check("abort_mem_address", {24'd0, mem_address}, 32'd0);
    check("abort_mem_i", mem_i, 32'd0);
    check("abort_no_write", wr_count - w0, 0);
    check("abort_mem5", mem[5], 32'h0BAD_F00D);

    // Streaming legal requests against the reference memory
    w0 = wr_count;
    nstores = 0;
    for (int k = 0; k < 16; k++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? st_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
      if (f3 == 3'b010) a[1:0] = 2'b00;
      wd = $urandom;
      if (wr) begin
        nstores++;
        ex = 32'd0;
        issue(1, f3, a, wd, ex, 0, (f3 == 3'b010) ? 2 : 3, 1, t);
      end else begin
        ex = model_load(ref_mem[a[9:2]], a[1:0], f3);
        issue(0, f3, a, 0, ex, 0, 2, 1, t);
      end
    end
    wait_drain();
    check("stream_write_count", wr_count - w0, nstores);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("stream_mem_words_differing", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
